// File: rtl/zqh_jtag_dtm_tap.sv
// JTAG TAP controller plus RISC-V debug transport module, oversampling the JTAG pins on clock.
// DMI scans become request/response transactions toward the debug module.
module zqh_jtag_dtm_tap #(
    parameter int          ABITS     = 7,
    parameter logic [31:0] IDCODE    = 32'h00000001,
    parameter logic [2:0]  IDLE_HINT = 3'd1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             jtag_tck,
    input  logic             jtag_tms,
    input  logic             jtag_tdi,
    output logic             jtag_tdo,
    output logic             jtag_tdo_en,
    output logic             dmi_req_valid,
    input  logic             dmi_req_ready,
    output logic [ABITS-1:0] dmi_req_addr,
    output logic [31:0]      dmi_req_data,
    output logic [1:0]       dmi_req_op,
    input  logic             dmi_resp_valid,
    output logic             dmi_resp_ready,
    input  logic [31:0]      dmi_resp_data,
    input  logic [1:0]       dmi_resp_resp
);
    localparam int         DMI_W       = ABITS + 34;
    localparam logic [4:0] IR_IDCODE   = 5'h01;
    localparam logic [4:0] IR_DTMCS    = 5'h10;
    localparam logic [4:0] IR_DMI      = 5'h11;
    localparam logic [5:0] ABITS_FIELD = 6'(ABITS);

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET, RUN_TEST_IDLE,
        SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR,
        SELECT_IR, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
    } tap_state_t;

    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        case (s)
            TEST_LOGIC_RESET: tap_next = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    tap_next = tms ? SELECT_DR : RUN_TEST_IDLE;
            SELECT_DR:        tap_next = tms ? SELECT_IR : CAPTURE_DR;
            CAPTURE_DR:       tap_next = tms ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR:         tap_next = tms ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR:         tap_next = tms ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:         tap_next = tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR:         tap_next = tms ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:        tap_next = tms ? SELECT_DR : RUN_TEST_IDLE;
            SELECT_IR:        tap_next = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       tap_next = tms ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR:         tap_next = tms ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR:         tap_next = tms ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:         tap_next = tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR:         tap_next = tms ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:        tap_next = tms ? SELECT_DR : RUN_TEST_IDLE;
            default:          tap_next = TEST_LOGIC_RESET;
        endcase
    endfunction

    // Pin order in the sync vector: 0=tck, 1=tms, 2=tdi.
    logic [2:0] pin_raw;
    logic [2:0] pin_sync;
    assign pin_raw = {jtag_tdi, jtag_tms, jtag_tck};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clock) begin
                if (reset) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= pin_raw[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign pin_sync[gi] = sync_reg;
        end
    endgenerate

    tap_state_t       state_reg;
    logic             tck_d_reg;
    logic [4:0]       ir_reg;
    logic [4:0]       ir_shift_reg;
    logic [DMI_W-1:0] dr_shift_reg;
    logic [DMI_W-1:0] dr_shift_next;
    logic [DMI_W-1:0] dr_capture;
    logic             tdo_reg;
    logic             tdo_en_reg;
    logic             req_valid_reg;
    logic [ABITS-1:0] req_addr_reg;
    logic [31:0]      req_data_reg;
    logic [1:0]       req_op_reg;
    logic             busy_reg;
    logic [1:0]       sticky_reg;
    logic [31:0]      last_data_reg;
    logic             tck_rise;
    logic             tck_fall;

    assign tck_rise = pin_sync[0] & ~tck_d_reg;
    assign tck_fall = ~pin_sync[0] & tck_d_reg;

    // The selected DR length decides which bit the incoming tdi lands in.
    always_comb begin
        dr_capture    = '0;
        dr_shift_next = {{(DMI_W-1){1'b0}}, pin_sync[2]};
        case (ir_reg)
            IR_IDCODE: begin
                dr_capture[31:0] = IDCODE;
                dr_shift_next    = {{(DMI_W-32){1'b0}}, pin_sync[2], dr_shift_reg[31:1]};
            end
            IR_DTMCS: begin
                dr_capture[31:0] = {14'b0, 1'b0, 1'b0, 1'b0, IDLE_HINT, sticky_reg,
                                    ABITS_FIELD, 4'd1};
                dr_shift_next    = {{(DMI_W-32){1'b0}}, pin_sync[2], dr_shift_reg[31:1]};
            end
            IR_DMI: begin
                dr_capture    = {req_addr_reg, last_data_reg, busy_reg ? 2'd3 : sticky_reg};
                dr_shift_next = {pin_sync[2], dr_shift_reg[DMI_W-1:1]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= TEST_LOGIC_RESET;
            tck_d_reg     <= 1'b0;
            ir_reg        <= IR_IDCODE;
            ir_shift_reg  <= '0;
            dr_shift_reg  <= '0;
            tdo_reg       <= 1'b0;
            tdo_en_reg    <= 1'b0;
            req_valid_reg <= 1'b0;
            req_addr_reg  <= '0;
            req_data_reg  <= '0;
            req_op_reg    <= '0;
            busy_reg      <= 1'b0;
            sticky_reg    <= '0;
            last_data_reg <= '0;
        end else begin
            tck_d_reg <= pin_sync[0];

            if (req_valid_reg && dmi_req_ready)
                req_valid_reg <= 1'b0;
            if (busy_reg && dmi_resp_valid) begin
                last_data_reg <= dmi_resp_data;
                if (sticky_reg == 2'd0)
                    sticky_reg <= dmi_resp_resp;
                busy_reg <= 1'b0;
            end

            if (tck_rise) begin
                state_reg <= tap_next(state_reg, pin_sync[1]);
                case (state_reg)
                    CAPTURE_IR: ir_shift_reg <= 5'b00001;
                    SHIFT_IR:   ir_shift_reg <= {pin_sync[2], ir_shift_reg[4:1]};
                    CAPTURE_DR: begin
                        dr_shift_reg <= dr_capture;
                        if (ir_reg == IR_DMI && busy_reg)
                            sticky_reg <= 2'd3;
                    end
                    SHIFT_DR:   dr_shift_reg <= dr_shift_next;
                    default: ;
                endcase
            end

            if (tck_fall) begin
                tdo_reg    <= (state_reg == SHIFT_DR) ? dr_shift_reg[0] :
                              (state_reg == SHIFT_IR) ? ir_shift_reg[0] : 1'b0;
                tdo_en_reg <= (state_reg == SHIFT_DR) || (state_reg == SHIFT_IR);
                if (state_reg == UPDATE_IR)
                    ir_reg <= ir_shift_reg;
                if (state_reg == UPDATE_DR && ir_reg == IR_DTMCS) begin
                    if (dr_shift_reg[17]) begin
                        sticky_reg    <= 2'd0;
                        busy_reg      <= 1'b0;
                        req_valid_reg <= 1'b0;
                    end else if (dr_shift_reg[16]) begin
                        sticky_reg <= 2'd0;
                    end
                end
                if (state_reg == UPDATE_DR && ir_reg == IR_DMI) begin
                    // A scan landing on a busy DMI is an overrun: flag it, keep the old request.
                    if (busy_reg) begin
                        sticky_reg <= 2'd3;
                    end else if (sticky_reg == 2'd0 &&
                                 (dr_shift_reg[1:0] == 2'd1 || dr_shift_reg[1:0] == 2'd2)) begin
                        req_addr_reg  <= dr_shift_reg[DMI_W-1:34];
                        req_data_reg  <= dr_shift_reg[33:2];
                        req_op_reg    <= dr_shift_reg[1:0];
                        req_valid_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                    end
                end
            end

            if (state_reg == TEST_LOGIC_RESET) begin
                ir_reg     <= IR_IDCODE;
                sticky_reg <= 2'd0;
            end
        end
    end

    assign jtag_tdo       = tdo_reg;
    assign jtag_tdo_en    = tdo_en_reg;
    assign dmi_req_valid  = req_valid_reg;
    assign dmi_req_addr   = req_addr_reg;
    assign dmi_req_data   = req_data_reg;
    assign dmi_req_op     = req_op_reg;
    assign dmi_resp_ready = busy_reg;

endmodule

// File: tb/tb_zqh_jtag_dtm_tap.sv
// Directed bench for zqh_jtag_dtm_tap: scans drive expected words into a scoreboard,
// independent monitors compare scan results and DMI requests as they appear.
module tb_zqh_jtag_dtm_tap;
    localparam int ABITS = 7;

    logic             clock = 1'b0;
    logic             reset;
    logic             jtag_tck, jtag_tms, jtag_tdi;
    logic             jtag_tdo, jtag_tdo_en;
    logic             dmi_req_valid, dmi_req_ready;
    logic [ABITS-1:0] dmi_req_addr;
    logic [31:0]      dmi_req_data;
    logic [1:0]       dmi_req_op;
    logic             dmi_resp_valid, dmi_resp_ready;
    logic [31:0]      dmi_resp_data;
    logic [1:0]       dmi_resp_resp;

    zqh_jtag_dtm_tap #(.ABITS(ABITS), .IDCODE(32'h00000001), .IDLE_HINT(3'd1)) dut (
        .clock(clock), .reset(reset),
        .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi),
        .jtag_tdo(jtag_tdo), .jtag_tdo_en(jtag_tdo_en),
        .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
        .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
        .dmi_resp_valid(dmi_resp_valid), .dmi_resp_ready(dmi_resp_ready),
        .dmi_resp_data(dmi_resp_data), .dmi_resp_resp(dmi_resp_resp)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          len;
        logic [63:0] data;
        string       name;
    } scan_exp_t;
    typedef struct {
        logic [ABITS-1:0] addr;
        logic [31:0]      data;
        logic [1:0]       op;
    } req_t;

    scan_exp_t   exp_scan_q[$];
    req_t        exp_req_q[$];
    logic [63:0] obs_data;
    logic        obs_en, obs_idle_tdo, obs_idle_en;
    event        scan_ev;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic expect_scan(input string name, input int len, input logic [63:0] data);
        scan_exp_t e;
        e.name = name; e.len = len; e.data = data;
        exp_scan_q.push_back(e);
    endtask

    task automatic expect_req(input logic [ABITS-1:0] addr, input logic [31:0] data,
                              input logic [1:0] op);
        req_t r;
        r.addr = addr; r.data = data; r.op = op;
        exp_req_q.push_back(r);
    endtask

    // One TCK period: 4 clocks low, tdo sampled just before the rising edge, 4 clocks high.
    task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo, output logic en);
        jtag_tms = tms;
        jtag_tdi = tdi;
        repeat (4) @(posedge clock);
        #1;
        tdo = jtag_tdo;
        en  = jtag_tdo_en;
        jtag_tck = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        jtag_tck = 1'b0;
    endtask

    task automatic tck1(input logic tms);
        logic t, e;
        tck_cycle(tms, 1'b0, t, e);
    endtask

    // From Run-Test-Idle: full IR or DR scan, back to Run-Test-Idle.
    task automatic scan(input logic is_ir, input int len, input logic [63:0] din);
        logic        t, e, en_all;
        logic [63:0] dout;
        tck1(1'b1);
        if (is_ir) tck1(1'b1);
        tck1(1'b0);
        tck1(1'b0);
        dout   = '0;
        en_all = 1'b1;
        for (int i = 0; i < len; i++) begin
            tck_cycle(i == len - 1, din[i], t, e);
            dout[i] = t;
            en_all  = en_all & e;
        end
        tck1(1'b1);
        tck1(1'b0);
        repeat (4) @(posedge clock);
        #1;
        obs_data     = dout;
        obs_en       = en_all;
        obs_idle_tdo = jtag_tdo;
        obs_idle_en  = jtag_tdo_en;
        -> scan_ev;
    endtask

    // Scan monitor
    initial begin
        scan_exp_t   e;
        logic [63:0] mask;
        forever begin
            @(scan_ev);
            if (exp_scan_q.size() == 0) begin
                total++; bad++;
                $display("FAIL scan_unexpected: got %h expected none", obs_data);
            end else begin
                e    = exp_scan_q.pop_front();
                mask = (e.len >= 64) ? '1 : ((64'd1 << e.len) - 64'd1);
                check({e.name, "_data"}, obs_data & mask, e.data & mask);
                check({e.name, "_tdo_en"}, 64'(obs_en), 64'd1);
                check({e.name, "_idle"}, 64'({obs_idle_tdo, obs_idle_en}), 64'd0);
            end
        end
    end

    // DMI request monitor
    initial begin
        req_t r;
        forever begin
            @(negedge clock);
            if (dmi_req_valid && dmi_req_ready) begin
                if (exp_req_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL req_unexpected: got addr=%h op=%h expected none",
                             dmi_req_addr, dmi_req_op);
                end else begin
                    r = exp_req_q.pop_front();
                    check("req_addr", 64'(dmi_req_addr), 64'(r.addr));
                    check("req_data", 64'(dmi_req_data), 64'(r.data));
                    check("req_op", 64'(dmi_req_op), 64'(r.op));
                end
            end
        end
    end

    // Debug module model: reads return DEADBEEF, writes return 0, always resp=ok.
    initial begin
        logic [1:0] op;
        dmi_resp_valid = 1'b0;
        dmi_resp_data  = '0;
        dmi_resp_resp  = 2'd0;
        forever begin
            @(negedge clock);
            if (dmi_req_valid && dmi_req_ready) begin
                op = dmi_req_op;
                repeat (3) @(negedge clock);
                dmi_resp_data  = (op == 2'd1) ? 32'hDEADBEEF : 32'h0;
                dmi_resp_resp  = 2'd0;
                dmi_resp_valid = 1'b1;
                check("resp_ready", 64'(dmi_resp_ready), 64'd1);
                @(negedge clock);
                dmi_resp_valid = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        jtag_tck      = 1'b0;
        jtag_tms      = 1'b1;
        jtag_tdi      = 1'b0;
        dmi_req_ready = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("rst_tdo", 64'(jtag_tdo), 64'd0);
        check("rst_tdo_en", 64'(jtag_tdo_en), 64'd0);
        check("rst_req_valid", 64'(dmi_req_valid), 64'd0);
        check("rst_req_fields", 64'({dmi_req_addr, dmi_req_data, dmi_req_op}), 64'd0);
        check("rst_resp_ready", 64'(dmi_resp_ready), 64'd0);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // IDCODE is the default instruction
        tck1(1'b0);
        expect_scan("idcode", 32, 64'h1);
        scan(1'b0, 32, 64'h0);

        // DTMCS readback
        expect_scan("ir_cap", 5, 64'h01);
        scan(1'b1, 5, 64'h10);
        expect_scan("dtmcs", 32, 64'h1071);
        scan(1'b0, 32, 64'h0);

        // DMI read of 0x38
        dmi_req_ready = 1'b1;
        expect_scan("ir_cap", 5, 64'h01);
        scan(1'b1, 5, 64'h11);
        expect_req(7'h38, 32'h0, 2'd1);
        expect_scan("dmi_first", 41, 64'h0);
        scan(1'b0, 41, 64'({7'h38, 32'h0, 2'd1}));
        expect_scan("dmi_rdata", 41, 64'({7'h38, 32'hDEADBEEF, 2'd0}));
        scan(1'b0, 41, 64'h0);

        // DMI write held off by ready=0, overrun while busy
        dmi_req_ready = 1'b0;
        expect_req(7'h39, 32'h80000000, 2'd2);
        expect_scan("dmi_wr", 41, 64'({7'h38, 32'hDEADBEEF, 2'd0}));
        scan(1'b0, 41, 64'({7'h39, 32'h80000000, 2'd2}));
        expect_scan("dmi_busy", 41, 64'({7'h39, 32'hDEADBEEF, 2'd3}));
        scan(1'b0, 41, 64'h0);
        check("req_still_valid", 64'(dmi_req_valid), 64'd1);

        // dmireset clears sticky
        expect_scan("ir_cap", 5, 64'h01);
        scan(1'b1, 5, 64'h10);
        expect_scan("dtmcs_sticky", 32, 64'h1C71);
        scan(1'b0, 32, 64'h00010000);
        expect_scan("dtmcs_clear", 32, 64'h1071);
        scan(1'b0, 32, 64'h0);

        // Release the held write; response data for a write is 0
        dmi_req_ready = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        expect_scan("ir_cap", 5, 64'h01);
        scan(1'b1, 5, 64'h11);
        expect_scan("dmi_after_wr", 41, 64'({7'h39, 32'h0, 2'd0}));
        scan(1'b0, 41, 64'h0);

        // Five tms=1 from Shift-DR lands in Test-Logic-Reset
        tck1(1'b1);
        tck1(1'b0);
        tck1(1'b0);
        repeat (5) tck1(1'b1);
        tck1(1'b0);
        expect_scan("idcode_tlr", 32, 64'h1);
        scan(1'b0, 32, 64'h0);

        // Unknown IR selects bypass: one-TCK delay
        expect_scan("ir_cap", 5, 64'h01);
        scan(1'b1, 5, 64'h07);
        expect_scan("bypass", 4, 64'b1010);
        scan(1'b0, 4, 64'b1101);

        for (int i = 0; i < 200 && (exp_scan_q.size() != 0 || exp_req_q.size() != 0); i++)
            @(posedge clock);
        check("scan_q_drained", 64'(exp_scan_q.size()), 64'd0);
        check("req_q_drained", 64'(exp_req_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
